// File: rtl/mult_arbiter.sv
// -----------------------------------------------------------------------------
// mult_arbiter
//
// Purpose:
//   Shares one shift-and-add unsigned multiplier among four requesters.
//   While idle, the block picks one valid requester, captures its operands,
//   runs exactly SIZE add/shift iterations, then holds the product until the
//   consumer takes it.
//
// Configuration:
//   MULT_ARB_FIXED_PRIO_EN
//     undefined (default): round-robin arbitration with a rotating pointer.
//     defined:             fixed priority; the lowest-indexed valid requester
//                          wins and there is no pointer.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous reset, active-low
//   req_valid  in   [NREQ-1:0]       requester k presents operands
//   req_ready  out  [NREQ-1:0]       one-hot grant, only while idle
//   req_a      in   [NREQ*SIZE-1:0]  multiplicand k at [k*SIZE +: SIZE]
//   req_b      in   [NREQ*SIZE-1:0]  multiplier k at [k*SIZE +: SIZE]
//   res_valid  out                   product available
//   res_ready  in                    consumer accepts the product
//   res_id     out  [1:0]            requester that owns res_data
//   res_data   out  [2*SIZE-1:0]     unsigned product
//   busy       out                   high whenever not idle
// -----------------------------------------------------------------------------
module mult_arbiter #(
  parameter int SIZE = 8,
  parameter int NREQ = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*SIZE-1:0]   req_a,
  input  logic [NREQ*SIZE-1:0]   req_b,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [1:0]             res_id,
  output logic [2*SIZE-1:0]      res_data,
  output logic                   busy
);

  localparam int CW = $clog2(SIZE + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [SIZE-1:0]   a_slice [NREQ];
  logic [SIZE-1:0]   b_slice [NREQ];
  logic [NREQ-1:0]   grant;
  logic [1:0]        win_id;
  logic              take;
  logic              last_iter;

  logic [2*SIZE-1:0] mcand;
  logic [SIZE-1:0]   mplier;
  logic [2*SIZE-1:0] acc;
  logic [2*SIZE-1:0] acc_sum;
  logic [CW-1:0]     cnt;
  logic [1:0]        cur_id;

  // Unpack the flat operand buses so the winner can be selected by index.
  always_comb begin
    for (int k = 0; k < NREQ; k++) begin
      a_slice[k] = req_a[k*SIZE +: SIZE];
      b_slice[k] = req_b[k*SIZE +: SIZE];
    end
  end

`ifdef MULT_ARB_FIXED_PRIO_EN
  // Fixed priority: scanning from the top down lets the lowest valid index
  // overwrite any higher one, so it ends up as the winner.
  always_comb begin
    grant  = '0;
    win_id = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[k]) begin
        grant    = '0;
        grant[k] = 1'b1;
        win_id   = 2'(k);
      end
    end
  end
`else
  logic [1:0] rr_ptr;

  // Round-robin: search starts at the pointer and wraps modulo 4; the first
  // valid requester found wins.
  always_comb begin
    logic [1:0] idx;
    logic       found;
    grant  = '0;
    win_id = '0;
    found  = 1'b0;
    idx    = rr_ptr;
    for (int i = 0; i < NREQ; i++) begin
      idx = rr_ptr + 2'(i);
      if (!found && req_valid[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        win_id      = idx;
      end
    end
  end

  // The pointer moves just past the winner on every accepted transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= 2'd0;
    end else if (take) begin
      rr_ptr <= win_id + 2'd1;
    end
  end
`endif

  // Grants are visible only while idle and out of reset; a grant seen by a
  // valid requester is by construction a transfer.
  assign take      = (state == IDLE) && (|grant);
  assign req_ready = ((state == IDLE) && rst) ? grant : '0;
  assign busy      = (state != IDLE);
  assign last_iter = (state == RUN) && (cnt == CW'(SIZE - 1));
  assign acc_sum   = acc + (mplier[0] ? mcand : '0);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. RUN always lasts SIZE cycles, even for zero operands,
  // so the latency is fixed.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (take)      state_next = RUN;
      RUN:     if (last_iter) state_next = DONE;
      DONE:    if (res_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // Datapath. The final iteration writes its sum straight into res_data so
  // the product appears on the same edge that enters DONE. res_data/res_id
  // are only rewritten there, so they keep their value after acceptance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
      cur_id    <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (take) begin
            mcand  <= {{SIZE{1'b0}}, a_slice[win_id]};
            mplier <= b_slice[win_id];
            acc    <= '0;
            cnt    <= '0;
            cur_id <= win_id;
          end
        end
        RUN: begin
          acc    <= acc_sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (last_iter) begin
            res_data  <= acc_sum;
            res_id    <= cur_id;
            res_valid <= 1'b1;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
          end
        end
        default: begin
          res_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mult_arbiter
//
// Purpose:
//   Directed self-checking bench for mult_arbiter with SIZE=8. Expected
//   grants and products are hand-computed constants; the round-robin versus
//   fixed-priority expectations follow MULT_ARB_FIXED_PRIO_EN.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_mult_arbiter;

  localparam int SIZE = 8;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        res_valid;
  logic        res_ready;
  logic [1:0]  res_id;
  logic [15:0] res_data;
  logic        busy;

  int checks = 0;
  int errors = 0;

  mult_arbiter #(.SIZE(SIZE), .NREQ(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_data  (res_data),
    .busy      (busy)
  );

  // Free-running clock; inputs change and outputs are sampled at negedge.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the sequence itself gets stuck.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [3:0] valid, input logic [31:0] a,
                                input logic [31:0] b, input logic rdy);
    req_valid = valid;
    req_a     = a;
    req_b     = b;
    res_ready = rdy;
    #1;
  endtask

  // Grant check, transfer, RUN-phase check, then wait for res_valid with a
  // bounded cycle count and check latency and result.
  task automatic transaction(input string tag, input logic [3:0] exp_ready,
                             input logic [1:0] exp_id, input logic [15:0] exp_data,
                             input bit scramble);
    int lat;
    check_output({tag, "_grant"}, 32'(req_ready), 32'(exp_ready));
    check_output({tag, "_busy_idle"}, 32'(busy), 32'd0);
    @(posedge clk);
    @(negedge clk);
    if (scramble) begin
      req_valid = 4'b0000;
      req_a     = $urandom;
      req_b     = $urandom;
      #1;
    end
    check_output({tag, "_ready_run"}, 32'(req_ready), 32'd0);
    check_output({tag, "_busy_run"}, 32'(busy), 32'd1);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (res_valid === 1'b1) break;
    end
    #1;
    check_output({tag, "_latency"}, 32'(lat), 32'(SIZE));
    check_output({tag, "_data"}, 32'(res_data), 32'(exp_data));
    check_output({tag, "_id"}, 32'(res_id), 32'(exp_id));
  endtask

  // Result handshake: no grant may appear in the accepting cycle, and the
  // block must be idle one edge later.
  task automatic accept(input string tag);
    res_ready = 1'b1;
    #1;
    check_output({tag, "_ready_accept"}, 32'(req_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    #1;
    check_output({tag, "_valid_after"}, 32'(res_valid), 32'd0);
    check_output({tag, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int  k;
    bit  seen;
    logic [3:0] onehot;

    // Reset with requests present: nothing may be granted.
    rst = 1'b0;
    apply_stimulus(4'hF, 32'h0403_0201, 32'h0101_0101, 1'b1);
    repeat (2) @(negedge clk);
    #1;
    check_output("rst_res_valid", 32'(res_valid), 32'd0);
    check_output("rst_res_data", 32'(res_data), 32'd0);
    check_output("rst_res_id", 32'(res_id), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_req_ready", 32'(req_ready), 32'd0);
    rst = 1'b1;
    apply_stimulus(4'h0, 32'h0, 32'h0, 1'b1);
    @(negedge clk);

    // Single requester 2, 255*255, operands scrambled after the transfer.
    apply_stimulus(4'b0100, 32'h00FF_0000, 32'h00FF_0000, 1'b1);
    transaction("single", 4'b0100, 2'd2, 16'hFE01, 1'b1);
    accept("single");
    check_output("single_data_kept", 32'(res_data), 32'hFE01);
    check_output("single_id_kept", 32'(res_id), 32'd2);

    // Zero multiplicand on requester 0 still takes the full latency.
    apply_stimulus(4'b0001, 32'h0000_0000, 32'h0000_00C8, 1'b1);
    transaction("zero", 4'b0001, 2'd0, 16'd0, 1'b0);
    accept("zero");
    apply_stimulus(4'b0000, 32'h0, 32'h0, 1'b1);

    // Backpressure: 7*9 on requester 1 held for 5 cycles, all requests up.
    apply_stimulus(4'b0010, 32'h0000_0700, 32'h0000_0900, 1'b0);
    transaction("bp", 4'b0010, 2'd1, 16'd63, 1'b0);
    req_valid = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      #1;
      check_output("bp_hold_valid", 32'(res_valid), 32'd1);
      check_output("bp_hold_data", 32'(res_data), 32'd63);
      check_output("bp_hold_id", 32'(res_id), 32'd1);
      check_output("bp_hold_ready", 32'(req_ready), 32'd0);
    end
    accept("bp");
    apply_stimulus(4'b0000, 32'h0, 32'h0, 1'b1);

    // Reset in the fourth RUN cycle aborts the job.
    apply_stimulus(4'b0100, 32'h0005_0000, 32'h0005_0000, 1'b1);
    check_output("abort_grant", 32'(req_ready), 32'b0100);
    @(posedge clk);
    @(negedge clk);
    req_valid = 4'b0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst       = 1'b0;
    req_valid = 4'hF;
    #1;
    check_output("abort_res_valid", 32'(res_valid), 32'd0);
    check_output("abort_res_data", 32'(res_data), 32'd0);
    check_output("abort_res_id", 32'(res_id), 32'd0);
    check_output("abort_busy", 32'(busy), 32'd0);
    check_output("abort_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    apply_stimulus(4'b0000, 32'h0, 32'h0, 1'b1);
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (res_valid === 1'b1) seen = 1'b1;
    end
    check_output("abort_no_result", 32'(seen), 32'd0);

    // All four requesting with a_k=k+3, b_k=10; pointer restarts at 0.
    apply_stimulus(4'hF, 32'h0605_0403, 32'h0A0A_0A0A, 1'b1);
    for (int n = 0; n < 5; n++) begin
`ifdef MULT_ARB_FIXED_PRIO_EN
      k = 0;
`else
      k = n % 4;
`endif
      onehot = 4'b0001 << k;
      transaction("sweep", onehot, 2'(k), 16'((k + 3) * 10), 1'b0);
      accept("sweep");
    end
    apply_stimulus(4'b0000, 32'h0, 32'h0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
